// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data-memory interface.
package mem_if_pkg;

    // Write-size encodings on data_write_size_2DM
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_B1   = 2'd1;
    localparam logic [1:0] SZ_B2   = 2'd2;
    localparam logic [1:0] SZ_B3   = 2'd3;

    // Responder FSM states (only used when LATENCY > 0)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Big-endian lane order: byte offset 0 lives in bits [31:24], i.e. mask bit 3
    function automatic logic [1:0] lane_slot(input logic [1:0] offset);
        return 2'd3 - offset;
    endfunction

endpackage

// File: rtl/byte_lane_mask.sv
// Byte-lane write mask for a big-endian word: (offset, size) -> mask, overrun.
// Mask bit i enables bits [8*i+7 : 8*i] of the word.
module byte_lane_mask
    import mem_if_pkg::*;
(
    input  logic [1:0] offset,
    input  logic [1:0] size,
    output logic [3:0] mask,
    output logic       overrun
);

    logic [2:0] nbytes;
    logic [2:0] first;
    logic [2:0] limit;

    // Enable lanes offset .. offset+n-1, clipped at the last lane of the word
    always_comb begin
        mask    = '0;
        overrun = 1'b0;
        first   = {1'b0, offset};
        case (size)
            SZ_WORD: nbytes = 3'd4;
            SZ_B1:   nbytes = 3'd1;
            SZ_B2:   nbytes = 3'd2;
            SZ_B3:   nbytes = 3'd3;
            default: nbytes = 3'd4;
        endcase
        limit = first + nbytes;
        if (size == SZ_WORD) begin
            mask = '1;
        end else begin
            for (int unsigned l = 0; l < 4; l++) begin
                if ((3'(l) >= first) && (3'(l) < limit))
                    mask[lane_slot(2'(l))] = 1'b1;
            end
            overrun = (limit > 3'd4);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with big-endian byte-lane stores and a
// configurable completion latency signalled through MEM_STALL_fDM.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    output logic [31:0] data_read_fDM,
    output logic        MEM_STALL_fDM
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_in;

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           wr_data;
    logic [1:0]            wr_off;
    logic [1:0]            wr_size;
    logic [3:0]            wr_mask;
    logic                  wr_overrun;

    // Word index after rebasing; upper bits drop so out-of-range addresses wrap
    assign idx_in = DEPTH_LOG2'((data_address_2DM - BASE_ADDR) >> 2);

    byte_lane_mask u_mask (
        .offset  (wr_off),
        .size    (wr_size),
        .mask    (wr_mask),
        .overrun (wr_overrun)
    );

    // Overrunning stores are legal; the mask already clips them
    cover property (@(posedge CLK) (wr_en && wr_overrun));

    // Array write port with per-lane enables; contents survive reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i])
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    if (LATENCY == 0) begin : g_comb
        assign wr_en         = MemWrite_2DM;
        assign wr_idx        = idx_in;
        assign wr_data       = data_write_2DM;
        assign wr_off        = data_address_2DM[1:0];
        assign wr_size       = data_write_size_2DM;
        assign data_read_fDM = mem[idx_in];
        assign MEM_STALL_fDM = 1'b0;
    end else begin : g_lat
        state_e                state;
        logic [2:0]            cnt;
        logic [DEPTH_LOG2-1:0] cap_idx;
        logic [31:0]           cap_data;
        logic [1:0]            cap_off;
        logic [1:0]            cap_size;
        logic                  cap_wr;
        logic [31:0]           rd_q;

        // The accept cycle is the first of the LATENCY stall cycles, so BUSY
        // starts one count down and LATENCY=1 skips BUSY entirely.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                state    <= IDLE;
                cnt      <= '0;
                cap_idx  <= '0;
                cap_data <= '0;
                cap_off  <= '0;
                cap_size <= '0;
                cap_wr   <= 1'b0;
                rd_q     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (MemRead_2DM || MemWrite_2DM) begin
                            cap_idx  <= idx_in;
                            cap_data <= data_write_2DM;
                            cap_off  <= data_address_2DM[1:0];
                            cap_size <= data_write_size_2DM;
                            cap_wr   <= MemWrite_2DM;
                            if (LATENCY == 1) begin
                                rd_q  <= mem[idx_in];
                                state <= DONE;
                            end else begin
                                cnt   <= 3'(LATENCY - 1);
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        if (cnt == 3'd1) begin
                            cnt   <= '0;
                            rd_q  <= mem[cap_idx];
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign wr_en         = (state == DONE) && cap_wr;
        assign wr_idx        = cap_idx;
        assign wr_data       = cap_data;
        assign wr_off        = cap_off;
        assign wr_size       = cap_size;
        assign data_read_fDM = rd_q;
        assign MEM_STALL_fDM = (state == BUSY) ||
                               ((state == IDLE) && (MemRead_2DM || MemWrite_2DM));
    end

endmodule
